// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the bubble (NOP) encoding, the HALT opcode, the default reset PC,
// the fetch state encoding and a small opcode helper used by the top.
package fetch_stage_pkg;

  localparam logic [15:0] PKG_NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE   = 5'b00000;
  localparam logic [15:0] PKG_RESET_PC  = 16'h0000;

  // The state bit is exported directly as the halted output.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_stage_cla16.sv
// 16-bit carry-lookahead adder used for the PC increment.
// Ports:
//   a, b   : 16-bit addends
//   c_in   : carry in
//   sum    : 16-bit sum (wraps)
//   c_out  : carry out of bit 15
// Four 4-bit groups; group carries are resolved by lookahead, bit carries
// inside a group are derived from the group carry-in.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic [16:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, then lookahead across the groups, then
  // per-bit carries inside each group from that group's carry-in.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &p[4*k +: 4];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    grp_c[0] = c_in;
    for (int k = 0; k < 4; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
    c[16] = grp_c[4];
  end

  assign sum   = p ^ c[15:0];
  assign c_out = c[16];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   imem_addr     : instruction memory address (the PC register)
//   imem_data     : instruction word for imem_addr, same cycle
//   stall         : downstream hazard, hold PC and IF/ID
//   redirect      : taken branch/jump, squash and refetch from redirect_pc
//   redirect_pc   : redirect target
//   instr_out     : IF/ID instruction
//   pc_2_out      : IF/ID fetched PC+2
//   valid_out     : IF/ID holds a real instruction
//   halted        : fetch stopped on HALT
//   err           : sticky misaligned redirect error
// Priority each cycle: redirect > stall > halted > normal fetch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = PKG_RESET_PC,
  parameter logic [15:0] NOP_INSTR = PKG_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_2_out,
  output logic        valid_out,
  output logic        halted,
  output logic        err
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  pc_2_q, pc_2_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [15:0]  pc_plus2;

  cla_16b u_pc_inc (
    .a     (pc_q),
    .b     (16'h0002),
    .c_in  (1'b0),
    .sum   (pc_plus2),
    .c_out ()
  );

  // State register and all datapath flops share the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc_2_q  <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_2_q  <= pc_2_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next state: a redirect always returns to RUN, even over a HALT seen in
  // the same cycle; a HALT is only recognised on an unstalled RUN fetch.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = RUN;
    end else if (!stall && state_q == RUN && is_halt(imem_data)) begin
      state_d = HALTED;
    end
  end

  // PC and IF/ID next values. On redirect pc_2 is left alone since the
  // slot is a bubble; the misaligned target is forced even and flagged.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc_2_d  = pc_2_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (redirect) begin
      pc_d    = {redirect_pc[15:1], 1'b0};
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      err_d   = err_q | redirect_pc[0];
    end else if (stall) begin
      pc_d = pc_q;
    end else if (state_q == HALTED) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus2;
      instr_d = imem_data;
      pc_2_d  = pc_plus2;
      valid_d = 1'b1;
    end
  end

  // Outputs are straight register taps.
  always_comb begin
    imem_addr = pc_q;
    instr_out = instr_q;
    pc_2_out  = pc_2_q;
    valid_out = valid_q;
    halted    = (state_q == HALTED);
    err       = err_q;
  end

endmodule
